vout_pixel_writer: RTL
======================

// Module: vout_pixel_writer
// PURPOSE
//  Sink for the scaled-pixel write stream (vout_wr_x/y/dat/valid) emitted by the bilinear stage.
//  - Converts each (x,y) write into a linear frame-buffer address and buffers {addr,data} in a FIFO.
//  - Drains the FIFO to the frame-buffer memory port over a valid/ready handshake.
//  - Reports end-of-frame completion, dropped-pixel overflow and out-of-range coordinates.
// PARAMETERS
//  ADDR_W      24  frame-buffer word address width
//  FIFO_DEPTH  16  buffer entries; power of 2, >=4
//  DATA_W      16  pixel width (RGB565)
// PORTS
//  vin_clk        in   1       clock
//  rst_n          in   1       async active-low reset
//  frame_sync_n   in   1       low = frame resync; sync clear of all state except sticky flags
//  vout_width     in   16      output frame width in pixels (>=1); sampled in IDLE only
//  vout_height    in   16      output frame height in lines (>=1); sampled in IDLE only
//  vout_wr_x      in   16      pixel column
//  vout_wr_y      in   16      pixel row
//  vout_wr_dat    in   DATA_W  pixel data
//  vout_wr_valid  in   1       pixel strobe; no backpressure (one pixel per cycle max)
//  mem_wr_en      out  1       memory write request
//  mem_wr_addr    out  ADDR_W  y*vout_width + x
//  mem_wr_data    out  DATA_W  pixel data
//  mem_wr_ready   in   1       memory accepts when mem_wr_en && mem_wr_ready
//  frame_done     out  1       one-cycle pulse: last pixel of frame written to memory
//  overflow       out  1       sticky: pixel dropped on FIFO full; cleared only by rst_n
//  coord_err      out  1       sticky: x>=width or y>=height seen; cleared only by rst_n
//  pix_count      out  32      pixels written to memory this frame
// BEHAVIOUR
//  Reset (rst_n low, async): all outputs 0, FIFO empty, state IDLE.
//  frame_sync_n low (sync, checked on every edge): FIFO flushed, stage reg cleared, mem_wr_en=0,
//    pix_count=0, frame_done=0, state IDLE; overflow/coord_err hold. A write in flight is abandoned.
//  FSM:
//    IDLE  -> RUN    when frame_sync_n high; latch width/height
//    RUN   -> DRAIN  when last pixel (x==width-1 && y==height-1) accepted into stage
//    DRAIN -> DONE   when FIFO empty, stage empty and no mem_wr_en pending
//    DONE  -> IDLE   unconditionally; frame_done=1 for this single cycle
//  Accept: vout_wr_valid sampled only in RUN; ignored (dropped, no flag) in IDLE/DRAIN/DONE.
//  Range: x>=width or y>=height -> pixel dropped, coord_err set; a dropped pixel never ends a frame.
//  Stage (edge E0): register {addr=y*width+x truncated to ADDR_W, data, last}.
//  Push (edge E1): stage entry written to FIFO.
//  Memory: show-ahead FIFO; mem_wr_en high at E2 earliest, so min latency valid->mem_wr_en = 2 clk.
//  Handshake: mem_wr_en/addr/data held stable until mem_wr_ready; back-to-back transfers allowed,
//    one per cycle at full rate; mem_wr_ready while mem_wr_en low has no effect.
//  Full: push with FIFO full and no same-cycle pop -> entry dropped, overflow set.
//    Push and pop in the same cycle when full -> both occur, count unchanged, no overflow.
//  Empty: mem_wr_en low; no pop.
//  pix_count: +1 per completed memory transfer; wraps at 2^32; cleared on IDLE entry.
//  Pointers: log2(FIFO_DEPTH)+1 bits; wrap naturally; full = MSBs differ, rest equal.
// STRUCTURE
//  Shared package vout_pkg: FSM state encodings (IDLE/RUN/DRAIN/DONE), RGB565 width constant,
//    FIFO entry typedef {addr, data}.
//  One sub-module: vout_wr_fifo (sync single-clock show-ahead FIFO, params WIDTH, DEPTH;
//    flush input driven by frame_sync_n low). Address multiply and FSM live in top.
// TESTING
//  1 width=4,height=2, 8 raster pixels, mem_wr_ready=1 -> addrs 0..7 in order, data matches,
//    first mem_wr_en 2 clk after first valid, frame_done one cycle after addr 7, pix_count=8.
//  2 same frame, mem_wr_ready low 20 cycles, FIFO_DEPTH=16 -> all 8 held, then drained in order,
//    no overflow, mem_wr_addr stable while stalled.
//  3 width=8,height=4, 32 pixels, mem_wr_ready=0 throughout -> 16 stored, overflow=1,
//    no frame_done until ready asserted and FIFO drains.
//  4 pixel x=9 on width=8 frame -> no memory write, coord_err=1, frame still ends on (7,3).
//  5 frame_sync_n low mid-frame with 5 entries queued -> mem_wr_en=0 next cycle, pix_count=0,
//    FIFO empty, overflow/coord_err unchanged; next frame writes from addr 0.
//  6 rst_n low mid-transfer -> all outputs 0 immediately; sticky flags cleared.

Source files
------------

// File: rtl/vout_pkg.sv
// Shared types for the scaled-pixel write path: writer FSM states and the
// {addr, data} entry carried from the stage register through the FIFO.
package vout_pkg;

  localparam int RGB565_W  = 16;
  localparam int FB_ADDR_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wr_state_t;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [RGB565_W-1:0]  data;
  } fifo_entry_t;

endpackage

// File: rtl/vout_wr_fifo.sv
// Single-clock show-ahead FIFO: the head entry is visible on pop_data while
// not empty. Flush empties it synchronously; drop flags a rejected push.
module vout_wr_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 16
) (
  input  logic             vin_clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full,
  output logic             drop
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // The extra pointer MSB separates full from empty when the indices match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                    (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign do_pop   = pop && !empty && !flush;
  assign do_push  = push && (!full || do_pop) && !flush;
  assign drop     = push && full && !do_pop && !flush;
  assign pop_data = mem[rd_ptr[IDX_W-1:0]];

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge vin_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge vin_clk) begin
    if (do_push) mem[wr_ptr[IDX_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/vout_pixel_writer.sv
// Frame-buffer sink for the bilinear output stream: stages (x,y) writes as
// linear addresses, buffers them and drains them over a valid/ready port.
module vout_pixel_writer
  import vout_pkg::*;
#(
  parameter int ADDR_W     = FB_ADDR_W,
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_W     = RGB565_W
) (
  input  logic              vin_clk,
  input  logic              rst_n,
  input  logic              frame_sync_n,
  input  logic [15:0]       vout_width,
  input  logic [15:0]       vout_height,
  input  logic [15:0]       vout_wr_x,
  input  logic [15:0]       vout_wr_y,
  input  logic [DATA_W-1:0] vout_wr_dat,
  input  logic              vout_wr_valid,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic              mem_wr_ready,
  output logic              frame_done,
  output logic              overflow,
  output logic              coord_err,
  output logic [31:0]       pix_count
);

  wr_state_t   state_q, state_d;
  logic [15:0] width_q, height_q;
  fifo_entry_t stage_q;
  logic        stage_vld_q;
  logic [31:0] pix_count_q;
  logic        overflow_q, coord_err_q;

  fifo_entry_t head;
  logic        fifo_empty, fifo_full, fifo_drop;
  logic        mem_pop;
  logic        in_range, is_last, stage_load, coord_bad;

  assign in_range   = (vout_wr_x < width_q) && (vout_wr_y < height_q);
  assign is_last    = (vout_wr_x == width_q - 16'd1) && (vout_wr_y == height_q - 16'd1);
  assign stage_load = (state_q == ST_RUN) && vout_wr_valid && in_range;
  assign coord_bad  = (state_q == ST_RUN) && vout_wr_valid && !in_range;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
    unique case (state_q)
      ST_IDLE:  state_d = ST_RUN;
      ST_RUN:   if (stage_load && is_last) state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_empty && !stage_vld_q) state_d = ST_DONE;
      ST_DONE: begin
        state_d    = ST_IDLE;
        frame_done = 1'b1;
      end
      default:  state_d = ST_IDLE;
    endcase
    if (!frame_sync_n) state_d = ST_IDLE;
  end

  always_ff @(posedge vin_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      width_q     <= '0;
      height_q    <= '0;
      stage_q     <= '0;
      stage_vld_q <= 1'b0;
      pix_count_q <= '0;
      overflow_q  <= 1'b0;
      coord_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      overflow_q  <= overflow_q | fifo_drop;
      coord_err_q <= coord_err_q | coord_bad;
      if (state_q == ST_IDLE) begin
        width_q  <= vout_width;
        height_q <= vout_height;
      end
      if (!frame_sync_n) begin
        stage_q     <= '0;
        stage_vld_q <= 1'b0;
        pix_count_q <= '0;
      end else begin
        stage_vld_q <= stage_load;
        if (stage_load) begin
          // Product and sum in 32 bits, then truncated to the frame-buffer address width.
          stage_q.addr <= FB_ADDR_W'({16'd0, vout_wr_y} * {16'd0, width_q} + {16'd0, vout_wr_x});
          stage_q.data <= vout_wr_dat;
        end
        if (state_q == ST_DONE)  pix_count_q <= '0;
        else if (mem_pop)        pix_count_q <= pix_count_q + 32'd1;
      end
    end
  end

  vout_wr_fifo #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .vin_clk   (vin_clk),
    .rst_n     (rst_n),
    .flush     (!frame_sync_n),
    .push      (stage_vld_q),
    .push_data (stage_q),
    .pop       (mem_pop),
    .pop_data  (head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .drop      (fifo_drop)
  );

  assign mem_wr_en   = !fifo_empty;
  assign mem_pop     = mem_wr_en && mem_wr_ready;
  // Bus fields read as zero while idle so stale storage never shows on the port.
  assign mem_wr_addr = mem_wr_en ? head.addr : '0;
  assign mem_wr_data = mem_wr_en ? head.data : '0;
  assign pix_count   = pix_count_q;
  assign overflow    = overflow_q;
  assign coord_err   = coord_err_q;

endmodule
